// File: rtl/branch_predict_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_predict_unit
// Brief    : Direct-mapped BTB with 2-bit counters. Predicts the next fetch PC
//            in IF, carries each prediction to EX, flags mispredicts and
//            trains the table. Optional perf counters under BPU_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module branch_predict_unit #(
    parameter int BTB_ENTRIES = 16,
    parameter int TAG_W       = 30 - $clog2(BTB_ENTRIES)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] if_pc,
    input  logic        stall,
    input  logic        id_ex_bubble,
    input  logic        flush,
    input  logic        ex_is_branch,
    input  logic        ex_is_jump,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
`ifdef BPU_PERF_CNT_EN
    output logic [31:0] br_count,
    output logic [31:0] mispred_count,
`endif
    output logic [31:0] pred_pc,
    output logic        pred_taken,
    output logic        mispredicted_pc,
    output logic [31:0] redirect_pc
);

    localparam int         IDX_W      = $clog2(BTB_ENTRIES);
    localparam logic [1:0] c_ctr_init = 2'b10;
    localparam logic [1:0] c_ctr_jump = 2'b11;

    function automatic logic [1:0] f_ctr_next(input logic [1:0] ctr, input logic up);
        logic [1:0] nxt;
        nxt = ctr;
        if (up && (ctr != 2'b11)) begin
            nxt = ctr + 2'd1;
        end else if (!up && (ctr != 2'b00)) begin
            nxt = ctr - 2'd1;
        end
        return nxt;
    endfunction

    // Flattened view of the per-entry BTB registers
    logic [BTB_ENTRIES-1:0] w_btb_valid;
    logic [TAG_W-1:0]       w_btb_tag    [BTB_ENTRIES];
    logic [31:0]            w_btb_target [BTB_ENTRIES];
    logic [1:0]             w_btb_ctr    [BTB_ENTRIES];

    // ------------------------------------------------------------------
    // IF-side lookup
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] w_if_idx;
    logic [TAG_W-1:0] w_if_tag;
    logic             w_if_hit;
    logic [31:0]      w_if_pc_inc;

    assign w_if_idx    = if_pc[IDX_W+1:2];
    assign w_if_tag    = if_pc[31 -: TAG_W];
    assign w_if_hit    = w_btb_valid[w_if_idx] && (w_btb_tag[w_if_idx] == w_if_tag);
    assign w_if_pc_inc = if_pc + 32'd4;
    assign pred_taken  = w_if_hit && w_btb_ctr[w_if_idx][1];
    assign pred_pc     = pred_taken ? w_btb_target[w_if_idx] : w_if_pc_inc;

    // ------------------------------------------------------------------
    // Shadow stages tracking the IF/ID and ID/EX pipeline registers
    // ------------------------------------------------------------------
    logic        r_id_valid;
    logic [31:0] r_id_pc;
    logic        r_id_p_taken;
    logic [31:0] r_id_p_target;
    logic        r_ex_valid;
    logic [31:0] r_ex_pc;
    logic        r_ex_p_taken;
    logic [31:0] r_ex_p_target;

    logic w_hold_all;
    logic w_ex_adv;

    assign w_hold_all = stall && !id_ex_bubble;
    assign w_ex_adv   = r_ex_valid && !w_hold_all;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_id_valid    <= 1'b0;
            r_id_pc       <= 32'd0;
            r_id_p_taken  <= 1'b0;
            r_id_p_target <= 32'd0;
            r_ex_valid    <= 1'b0;
            r_ex_pc       <= 32'd0;
            r_ex_p_taken  <= 1'b0;
            r_ex_p_target <= 32'd0;
        end else if (flush) begin
            r_id_valid <= 1'b0;
            r_ex_valid <= 1'b0;
        end else if (stall && id_ex_bubble) begin
            r_ex_valid <= 1'b0;
        end else if (!stall) begin
            r_ex_valid    <= r_id_valid;
            r_ex_pc       <= r_id_pc;
            r_ex_p_taken  <= r_id_p_taken;
            r_ex_p_target <= r_id_p_target;
            r_id_valid    <= 1'b1;
            r_id_pc       <= if_pc;
            r_id_p_taken  <= pred_taken;
            r_id_p_target <= pred_taken ? pred_pc : 32'd0;
        end
    end

    // ------------------------------------------------------------------
    // EX resolution
    // ------------------------------------------------------------------
    logic        w_ex_ctrl;
    logic [31:0] w_ex_pc_inc;
    logic [31:0] w_actual;
    logic        w_mispredict;

    assign w_ex_ctrl   = ex_is_branch || ex_is_jump;
    assign w_ex_pc_inc = r_ex_pc + 32'd4;

    always_comb begin
        w_actual     = w_ex_pc_inc;
        w_mispredict = 1'b0;
        if (w_ex_ctrl) begin
            if (ex_taken) begin
                w_actual = ex_target;
            end
            w_mispredict = (r_ex_p_taken != ex_taken) ||
                           (ex_taken && (r_ex_p_target != ex_target));
        end else begin
            // A predicted-taken non-control instruction is a BTB alias
            w_mispredict = r_ex_p_taken;
        end
    end

    assign mispredicted_pc = w_ex_adv && w_mispredict;
    assign redirect_pc     = mispredicted_pc ? w_actual : 32'd0;

    // ------------------------------------------------------------------
    // Training: one full-entry write per resolving instruction
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] w_ex_idx;
    logic [TAG_W-1:0] w_ex_tag;
    logic             w_ex_hit;
    logic             w_wr_en;
    logic             w_wr_valid;
    logic [31:0]      w_wr_target;
    logic [1:0]       w_wr_ctr;

    assign w_ex_idx = r_ex_pc[IDX_W+1:2];
    assign w_ex_tag = r_ex_pc[31 -: TAG_W];
    assign w_ex_hit = w_btb_valid[w_ex_idx] && (w_btb_tag[w_ex_idx] == w_ex_tag);

    always_comb begin
        w_wr_en     = 1'b0;
        w_wr_valid  = w_btb_valid[w_ex_idx];
        w_wr_target = w_btb_target[w_ex_idx];
        w_wr_ctr    = w_btb_ctr[w_ex_idx];
        if (w_ex_adv) begin
            if (ex_is_jump) begin
                w_wr_en     = 1'b1;
                w_wr_valid  = 1'b1;
                w_wr_target = ex_target;
                w_wr_ctr    = c_ctr_jump;
            end else if (ex_is_branch) begin
                if (w_ex_hit) begin
                    w_wr_en    = 1'b1;
                    w_wr_valid = 1'b1;
                    w_wr_ctr   = f_ctr_next(w_btb_ctr[w_ex_idx], ex_taken);
                    if (ex_taken) begin
                        w_wr_target = ex_target;
                    end
                end else if (ex_taken) begin
                    w_wr_en     = 1'b1;
                    w_wr_valid  = 1'b1;
                    w_wr_target = ex_target;
                    w_wr_ctr    = c_ctr_init;
                end
            end else if (w_ex_hit) begin
                w_wr_en    = 1'b1;
                w_wr_valid = 1'b0;
            end
        end
    end

    // Registered storage: same-cycle lookups see pre-write contents
    generate
        for (genvar g = 0; g < BTB_ENTRIES; g++) begin : g_btb
            logic             r_valid;
            logic [TAG_W-1:0] r_tag;
            logic [31:0]      r_target;
            logic [1:0]       r_ctr;
            logic             w_sel;

            assign w_sel = w_wr_en && (w_ex_idx == IDX_W'(g));

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_valid  <= 1'b0;
                    r_tag    <= '0;
                    r_target <= 32'd0;
                    r_ctr    <= c_ctr_init;
                end else if (w_sel) begin
                    r_valid  <= w_wr_valid;
                    r_tag    <= w_ex_tag;
                    r_target <= w_wr_target;
                    r_ctr    <= w_wr_ctr;
                end
            end

            assign w_btb_valid[g]  = r_valid;
            assign w_btb_tag[g]    = r_tag;
            assign w_btb_target[g] = r_target;
            assign w_btb_ctr[g]    = r_ctr;
        end
    endgenerate

`ifdef BPU_PERF_CNT_EN
    logic [31:0] r_br_count;
    logic [31:0] r_mispred_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_br_count      <= 32'd0;
            r_mispred_count <= 32'd0;
        end else begin
            if (w_ex_adv && w_ex_ctrl) begin
                r_br_count <= r_br_count + 32'd1;
            end
            if (mispredicted_pc) begin
                r_mispred_count <= r_mispred_count + 32'd1;
            end
        end
    end

    assign br_count      = r_br_count;
    assign mispred_count = r_mispred_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_predict_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_branch_predict_unit
// Brief    : Scoreboard bench for branch_predict_unit (BPU_PERF_CNT_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_predict_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] if_pc;
    logic        stall, id_ex_bubble, flush;
    logic        ex_is_branch, ex_is_jump, ex_taken;
    logic [31:0] ex_target;
    logic [31:0] pred_pc, redirect_pc;
    logic        pred_taken, mispredicted_pc;
`ifdef BPU_PERF_CNT_EN
    logic [31:0] br_count, mispred_count;
`endif

    branch_predict_unit dut (
        .clk             (clk),
        .reset           (reset),
        .if_pc           (if_pc),
        .stall           (stall),
        .id_ex_bubble    (id_ex_bubble),
        .flush           (flush),
        .ex_is_branch    (ex_is_branch),
        .ex_is_jump      (ex_is_jump),
        .ex_taken        (ex_taken),
        .ex_target       (ex_target),
`ifdef BPU_PERF_CNT_EN
        .br_count        (br_count),
        .mispred_count   (mispred_count),
`endif
        .pred_pc         (pred_pc),
        .pred_taken      (pred_taken),
        .mispredicted_pc (mispredicted_pc),
        .redirect_pc     (redirect_pc)
    );

    always #5 clk = ~clk;

    // One fetched instruction: its real behaviour plus the bench's expectations
    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic        br;
        logic        j;
        logic        tk;
        logic [31:0] tgt;
        logic        ep_tk;
        logic [31:0] ep_pc;
        logic        mis;
        logic [31:0] redir;
    } instr_t;

    instr_t tb_id, tb_ex;
    instr_t sb[$];
    int     pass_cnt  = 0;
    int     total_cnt = 0;
    string  cur = "";

    function automatic instr_t mk(input logic [31:0] pc, input logic br, input logic j,
                                  input logic tk, input logic [31:0] tgt,
                                  input logic ep_tk, input logic [31:0] ep_pc,
                                  input logic mis, input logic [31:0] redir);
        instr_t r;
        r.v = 1'b1; r.pc = pc; r.br = br; r.j = j; r.tk = tk; r.tgt = tgt;
        r.ep_tk = ep_tk; r.ep_pc = ep_pc; r.mis = mis; r.redir = redir;
        return r;
    endfunction

    function automatic instr_t nop(input logic [31:0] pc);
        return mk(pc, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, pc + 32'd4, 1'b0, 32'd0);
    endfunction

    // Drives one cycle; the hazard unit's flush follows the expected mispredict
    task automatic run_cycle(input instr_t f, input logic st, input logic bub);
        instr_t e;
        logic   adv;
        @(negedge clk);
        if_pc        = f.pc;
        stall        = st;
        id_ex_bubble = bub;
        ex_is_branch = tb_ex.v && tb_ex.br;
        ex_is_jump   = tb_ex.v && tb_ex.j;
        ex_taken     = tb_ex.v && tb_ex.tk;
        ex_target    = tb_ex.v ? tb_ex.tgt : 32'd0;
        adv          = tb_ex.v && !(st && !bub);
        flush        = adv && tb_ex.mis;
        #2;
        total_cnt += 2;
        if (pred_taken !== f.ep_tk)
            $display("FAIL %s pred_taken @%h: got %b want %b", cur, f.pc, pred_taken, f.ep_tk);
        else pass_cnt++;
        if (pred_pc !== f.ep_pc)
            $display("FAIL %s pred_pc @%h: got %h want %h", cur, f.pc, pred_pc, f.ep_pc);
        else pass_cnt++;
        if (adv) begin
            if (sb.size() == 0) begin
                total_cnt++;
                $display("FAIL %s scoreboard underflow: got resolve want none", cur);
            end else begin
                e = sb.pop_front();
                total_cnt += 2;
                if (mispredicted_pc !== e.mis)
                    $display("FAIL %s mispredicted_pc ex@%h: got %b want %b", cur, e.pc, mispredicted_pc, e.mis);
                else pass_cnt++;
                if (redirect_pc !== e.redir)
                    $display("FAIL %s redirect_pc ex@%h: got %h want %h", cur, e.pc, redirect_pc, e.redir);
                else pass_cnt++;
            end
        end else begin
            total_cnt++;
            if (mispredicted_pc !== 1'b0)
                $display("FAIL %s mispredicted_pc idle: got %b want 0", cur, mispredicted_pc);
            else pass_cnt++;
        end
        if (flush) begin
            if (tb_id.v) void'(sb.pop_back());
            tb_id.v = 1'b0;
            tb_ex.v = 1'b0;
        end else if (st && bub) begin
            tb_ex.v = 1'b0;
        end else if (!st) begin
            tb_ex = tb_id;
            tb_id = f;
            sb.push_back(f);
        end
    endtask

    task automatic drain();
        run_cycle(nop(32'h800), 1'b0, 1'b0);
        run_cycle(nop(32'h804), 1'b0, 1'b0);
    endtask

    task automatic clear_bench_pipe();
        tb_id.v = 1'b0;
        tb_ex.v = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        cur = "reset";
        reset = 1'b1; if_pc = 32'h100; stall = 0; id_ex_bubble = 0; flush = 0;
        ex_is_branch = 0; ex_is_jump = 0; ex_taken = 0; ex_target = 32'd0;
        #2;
        total_cnt += 4;
        if (pred_pc !== 32'h104) $display("FAIL reset pred_pc: got %h want 00000104", pred_pc); else pass_cnt++;
        if (pred_taken !== 1'b0) $display("FAIL reset pred_taken: got %b want 0", pred_taken); else pass_cnt++;
        if (mispredicted_pc !== 1'b0) $display("FAIL reset mispredicted_pc: got %b want 0", mispredicted_pc); else pass_cnt++;
        if (redirect_pc !== 32'd0) $display("FAIL reset redirect_pc: got %h want 0", redirect_pc); else pass_cnt++;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_bench_pipe();
    endtask

    task automatic test_cold_branch();
        cur = "cold_branch";
        run_cycle(mk(32'h100, 1, 0, 1, 32'h80, 0, 32'h104, 1, 32'h80), 0, 0);
        run_cycle(nop(32'h104), 0, 0);
        run_cycle(nop(32'h108), 0, 0);
        // ctr 10 -> predicted taken, resolves not taken
        run_cycle(mk(32'h100, 1, 0, 0, 32'h80, 1, 32'h80, 1, 32'h104), 0, 0);
        run_cycle(nop(32'h80), 0, 0);
        run_cycle(nop(32'h84), 0, 0);
        // ctr 01 -> predicted not taken
        run_cycle(mk(32'h100, 1, 0, 0, 32'h80, 0, 32'h104, 0, 32'd0), 0, 0);
        run_cycle(nop(32'h104), 0, 0);
        run_cycle(nop(32'h108), 0, 0);
        // ctr 00 saturates
        run_cycle(mk(32'h100, 1, 0, 0, 32'h80, 0, 32'h104, 0, 32'd0), 0, 0);
        run_cycle(nop(32'h104), 0, 0);
        run_cycle(nop(32'h108), 0, 0);
        drain();
    endtask

    task automatic test_jump();
        cur = "jump";
        run_cycle(mk(32'h200, 0, 1, 1, 32'h400, 0, 32'h204, 1, 32'h400), 0, 0);
        run_cycle(nop(32'h204), 0, 0);
        run_cycle(nop(32'h208), 0, 0);
        run_cycle(mk(32'h200, 0, 1, 1, 32'h400, 1, 32'h400, 0, 32'd0), 0, 0);
        run_cycle(nop(32'h400), 0, 0);
        run_cycle(nop(32'h404), 0, 0);
        drain();
    endtask

    task automatic test_alias();
        cur = "alias";
        // Non-control at a BTB-hit PC: mispredicts to pc+4 and invalidates
        run_cycle(mk(32'h200, 0, 0, 0, 32'd0, 1, 32'h400, 1, 32'h204), 0, 0);
        run_cycle(nop(32'h400), 0, 0);
        run_cycle(nop(32'h404), 0, 0);
        run_cycle(nop(32'h200), 0, 0);
        drain();
    endtask

    task automatic test_stall();
        cur = "stall";
        run_cycle(mk(32'h144, 1, 0, 1, 32'h500, 0, 32'h148, 1, 32'h500), 0, 0);
        run_cycle(nop(32'h148), 0, 0);
        run_cycle(nop(32'h14C), 1, 0);
        run_cycle(nop(32'h14C), 0, 0);
        // Trained once -> ctr 10; a not-taken pass must leave it at 01
        run_cycle(mk(32'h144, 1, 0, 0, 32'h500, 1, 32'h500, 1, 32'h148), 0, 0);
        run_cycle(nop(32'h500), 0, 0);
        run_cycle(nop(32'h504), 0, 0);
        run_cycle(mk(32'h144, 1, 0, 0, 32'h500, 0, 32'h148, 0, 32'd0), 0, 0);
        drain();
    endtask

    task automatic test_bubble();
        cur = "bubble";
        run_cycle(mk(32'h180, 1, 0, 0, 32'h600, 0, 32'h184, 0, 32'd0), 0, 0);
        run_cycle(mk(32'h184, 1, 0, 1, 32'h700, 0, 32'h188, 1, 32'h700), 0, 0);
        run_cycle(nop(32'h188), 1, 1);
        run_cycle(nop(32'h188), 0, 0);
        run_cycle(nop(32'h18C), 0, 0);
        run_cycle(mk(32'h184, 1, 0, 1, 32'h700, 1, 32'h700, 0, 32'd0), 0, 0);
        drain();
    endtask

    task automatic test_wrap();
        cur = "wrap";
        run_cycle(nop(32'hFFFF_FFFC), 0, 0);
        run_cycle(nop(32'h0), 0, 0);
        drain();
    endtask

`ifdef BPU_PERF_CNT_EN
    task automatic test_perf();
        cur = "perf";
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        clear_bench_pipe();
        total_cnt += 2;
        if (br_count !== 32'd0) $display("FAIL perf br_count after reset: got %0d want 0", br_count); else pass_cnt++;
        if (mispred_count !== 32'd0) $display("FAIL perf mispred_count after reset: got %0d want 0", mispred_count); else pass_cnt++;
        run_cycle(mk(32'h100, 1, 0, 0, 32'h80, 0, 32'h104, 0, 32'd0), 0, 0);
        run_cycle(mk(32'h104, 1, 0, 0, 32'h80, 0, 32'h108, 0, 32'd0), 0, 0);
        run_cycle(mk(32'h108, 1, 0, 1, 32'h80, 0, 32'h10C, 1, 32'h80), 0, 0);
        run_cycle(nop(32'h10C), 0, 0);
        run_cycle(nop(32'h110), 0, 0);
        run_cycle(nop(32'h114), 0, 0);
        @(posedge clk); #1;
        total_cnt += 2;
        if (br_count !== 32'd3) $display("FAIL perf br_count: got %0d want 3", br_count); else pass_cnt++;
        if (mispred_count !== 32'd1) $display("FAIL perf mispred_count: got %0d want 1", mispred_count); else pass_cnt++;
        reset = 1'b1;
        #1;
        total_cnt += 2;
        if (br_count !== 32'd0) $display("FAIL perf br_count mid reset: got %0d want 0", br_count); else pass_cnt++;
        if (mispred_count !== 32'd0) $display("FAIL perf mispred_count mid reset: got %0d want 0", mispred_count); else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        clear_bench_pipe();
    endtask
`endif

    task automatic test_reset_mid();
        instr_t e;
        cur = "reset_mid";
        run_cycle(mk(32'h300, 1, 0, 1, 32'h900, 0, 32'h304, 1, 32'h900), 0, 0);
        run_cycle(nop(32'h304), 0, 0);
        @(negedge clk);
        if_pc = 32'h308; stall = 0; id_ex_bubble = 0; flush = 0;
        ex_is_branch = 1; ex_is_jump = 0; ex_taken = 1; ex_target = 32'h900;
        #2;
        e = sb.pop_front();
        total_cnt += 2;
        if (mispredicted_pc !== e.mis) $display("FAIL reset_mid pre mispredicted_pc: got %b want %b", mispredicted_pc, e.mis); else pass_cnt++;
        if (redirect_pc !== e.redir) $display("FAIL reset_mid pre redirect_pc: got %h want %h", redirect_pc, e.redir); else pass_cnt++;
        reset = 1'b1;
        #1;
        total_cnt += 3;
        if (mispredicted_pc !== 1'b0) $display("FAIL reset_mid mispredicted_pc: got %b want 0", mispredicted_pc); else pass_cnt++;
        if (redirect_pc !== 32'd0) $display("FAIL reset_mid redirect_pc: got %h want 0", redirect_pc); else pass_cnt++;
        if (pred_pc !== 32'h30C) $display("FAIL reset_mid pred_pc: got %h want 0000030c", pred_pc); else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        ex_is_branch = 0; ex_taken = 0; ex_target = 32'd0;
        clear_bench_pipe();
        // The branch at 0x300 never trained: still a cold miss
        run_cycle(nop(32'h300), 0, 0);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        tb_id.v = 1'b0;
        tb_ex.v = 1'b0;
        test_reset();
        test_cold_branch();
        test_jump();
        test_alias();
        test_stall();
        test_bubble();
        test_wrap();
`ifdef BPU_PERF_CNT_EN
        test_perf();
`endif
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Fetch-side branch predictor for the pipelined RV32I core with forwarding. It replaces the static always-taken scheme with a direct-mapped BTB and 2-bit saturating counters.
- It predicts the next fetch PC in IF and shadows each prediction through ID and EX in lockstep with the datapath registers.
- When the hazard/forwarding unit resolves a branch in EX, this block compares the outcome with the prediction. It produces mispredicted_pc and the redirect PC that the hazard unit uses to flush, and it trains the BTB.

Parameters:
- BTB_ENTRIES, 16: number of BTB entries. Power of two, minimum 4. IDX_W = log2(BTB_ENTRIES).
- TAG_W, 30-IDX_W: tag width, taken from if_pc[31:IDX_W+2].

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- if_pc  in  32  PC currently being fetched
- stall  in  1  hazard-unit stall; freezes PC and IF/ID
- id_ex_bubble  in  1  hazard unit is inserting a bubble into ID/EX
- flush  in  1  hazard-unit flush; kills IF/ID and ID/EX contents
- ex_is_branch  in  1  instruction in EX is B-type
- ex_is_jump  in  1  instruction in EX is JAL or JALR
- ex_taken  in  1  resolved branch_taken from the hazard unit
- ex_target  in  32  resolved target address computed in EX
- pred_pc  out  32  next fetch PC
- pred_taken  out  1  BTB hit with predicted-taken
- mispredicted_pc  out  1  EX outcome differs from prediction
- redirect_pc  out  32  correct next PC, valid while mispredicted_pc=1

Behaviour:
- BTB entry = {valid, tag[TAG_W], target[32], ctr[2]}. Index = if_pc[IDX_W+1:2].
- Reset (async): every valid=0, every ctr=2'b10. Shadow stages s_id and s_ex get valid=0.
- Outputs during reset: pred_taken=0, mispredicted_pc=0, redirect_pc=0, pred_pc=if_pc+4.
- Lookup is combinational, zero latency:
  - hit = valid && tag match.
  - pred_taken = hit && ctr[1].
  - pred_pc = pred_taken ? target : if_pc+4.
  - All adds are modulo 2^32; 0xFFFFFFFC+4 wraps to 0.
- Shadow stage fields: {valid, pc, p_taken, p_target}. Update at posedge in this priority order:
  1. flush: s_id.valid<=0, s_ex.valid<=0.
  2. stall && id_ex_bubble: s_id holds; s_ex.valid<=0.
  3. stall && !id_ex_bubble: s_id and s_ex both hold.
  4. otherwise: s_ex<=s_id, and s_id<={1, if_pc, pred_taken, pred_pc-if-taken}.
- ex_adv = s_ex.valid && !(stall && !id_ex_bubble). Resolution and training occur only in ex_adv cycles, so each instruction resolves exactly once.
- Resolution (combinational, ex_adv=1):
  - For a branch or jump: actual = ex_taken ? ex_target : s_ex.pc+4.
  - A branch or jump mispredicts if p_taken != ex_taken, or if ex_taken && p_target != ex_target.
  - A non-control instruction with p_taken=1 (BTB alias) mispredicts, with actual = pc+4.
  - On mispredict: mispredicted_pc=1, redirect_pc=actual. Otherwise mispredicted_pc=0, redirect_pc=0.
- Training (posedge, ex_adv=1), indexed by s_ex.pc:
  - Branch, entry hit: ctr saturating +1 if taken, -1 if not. target<=ex_target when taken.
  - Branch, miss, taken: allocate {1, tag, ex_target, 2'b10}.
  - Branch, miss, not taken: no write.
  - Jump: write {1, tag, ex_target, 2'b11}, overwriting any entry.
  - Non-control with tag hit: valid<=0.
- Same-cycle BTB write and lookup of the same index: the lookup sees the pre-write content.
- flush in the same cycle as ex_adv: resolution and training still apply to the current s_ex. The flush only clears the shadow stages afterward.
- Reset mid-operation: all state clears immediately. mispredicted_pc drops to 0 in the same cycle.

Optional Feature:
- Macro BPU_PERF_CNT_EN.
- When defined, adds two 32-bit outputs, br_count and mispred_count:
  - Both reset to 0.
  - br_count increments on every ex_adv cycle with ex_is_branch||ex_is_jump.
  - mispred_count increments on every cycle with mispredicted_pc=1.
  - Both wrap at 2^32.
- When undefined, neither the ports nor the counters exist, and all other behaviour is identical.

Test Plan:
- After reset, if_pc=0x100 -> pred_pc=0x104, pred_taken=0, mispredicted_pc=0.
- Cold taken BEQ at 0x100, target 0x80, resolves in EX (2 cycles later) -> mispredicted_pc=1, redirect_pc=0x80. The next fetch of 0x100 then gives pred_taken=1, pred_pc=0x80.
- Same branch not taken twice -> ctr goes 10->01->00. The 2nd resolution gives mispredicted_pc=1 with redirect_pc=0x104; the next fetch gives pred_pc=0x104.
- JAL at 0x200 -> 0x400 resolved once -> entry ctr=11. Refetch of 0x200: pred_pc=0x400, and EX resolution gives mispredicted_pc=0.
- Load-use stall (stall=1, id_ex_bubble=0 for 1 cycle) with a branch in EX -> no mispredict/training during the stall cycle. Training happens exactly once when it advances, checked via ctr or br_count+1.
- With BPU_PERF_CNT_EN: 3 branches, 1 mispredicted -> br_count=3, mispred_count=1. Asserting reset mid-run -> both read 0.
